// File: rtl/mfcc_frontend_mc_if.sv
// Streaming bus between the PCM source, the multi-channel MFCC front end and the FFT stage.
// slave = front end view, master = source/sink view.
interface mfcc_frontend_mc_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int NUM_CH       = 2,
  parameter int FFT_SIZE     = 512
);
  localparam int CH_W  = (NUM_CH > 1)   ? $clog2(NUM_CH)   : 1;
  localparam int IDX_W = (FFT_SIZE > 1) ? $clog2(FFT_SIZE) : 1;

  logic                           pcm_valid_i;
  logic                           pcm_ready_o;
  logic [CH_W-1:0]                pcm_ch_i;
  logic signed [SAMPLE_WIDTH-1:0] pcm_i;
  logic                           out_valid_o;
  logic                           out_ready_i;
  logic [CH_W-1:0]                out_ch_o;
  logic [IDX_W-1:0]               out_idx_o;
  logic signed [SAMPLE_WIDTH-1:0] out_sample_o;
  logic                           out_last_o;
  logic                           frame_done_o;

  modport slave (
    input  pcm_valid_i, pcm_ch_i, pcm_i, out_ready_i,
    output pcm_ready_o, out_valid_o, out_ch_o, out_idx_o, out_sample_o, out_last_o, frame_done_o
  );

  modport master (
    output pcm_valid_i, pcm_ch_i, pcm_i, out_ready_i,
    input  pcm_ready_o, out_valid_o, out_ch_o, out_idx_o, out_sample_o, out_last_o, frame_done_o
  );
endinterface

// File: rtl/mfcc_frontend_mc.sv
// Multi-channel MFCC input stage: per-channel pre-emphasis, sample ring and
// zero-padded overlapping frame emission over a valid/ready stream.
//
// state  | meaning
// IDLE   | accepting samples, waiting for a channel to complete a frame
// EMIT   | streaming FFT_SIZE samples of the latched channel
// DONE   | one-cycle frame_done pulse, input re-enabled on exit
module mfcc_frontend_mc #(
  parameter int          SAMPLE_WIDTH = 16,
  parameter int          NUM_CH       = 2,
  parameter int          FRAME_SIZE   = 400,
  parameter int          FRAME_MOVE   = 160,
  parameter int          FFT_SIZE     = 512,
  parameter logic [15:0] ALPHA        = 16'd31785
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  input  logic                emph_en_i,
  mfcc_frontend_mc_if.slave   bus
);
  localparam int W     = SAMPLE_WIDTH;
  localparam int PW    = W + 17;
  localparam int CH_W  = (NUM_CH > 1)     ? $clog2(NUM_CH)     : 1;
  localparam int PTR_W = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam int CNT_W = $clog2(FRAME_SIZE + 1);
  localparam int IDX_W = (FFT_SIZE > 1)   ? $clog2(FFT_SIZE)   : 1;
  localparam int SUM_W = IDX_W + 1;

  localparam logic [CNT_W-1:0]     FS_C     = CNT_W'(FRAME_SIZE);
  localparam logic [CNT_W-1:0]     MOVE_C   = CNT_W'(FRAME_MOVE);
  localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(FRAME_SIZE - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(FFT_SIZE - 1);
  localparam logic [SUM_W-1:0]     FS_SUM   = SUM_W'(FRAME_SIZE);
  localparam logic [CH_W:0]        NUM_CH_C = (CH_W + 1)'(NUM_CH);
  localparam logic signed [PW-1:0] SAT_MAX  = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN  = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

  // per-channel state
  logic signed [W-1:0] prev_q [NUM_CH];
  logic [CNT_W-1:0]    fill_q [NUM_CH];
  logic [CNT_W-1:0]    new_q  [NUM_CH];
  logic [PTR_W-1:0]    wp_q   [NUM_CH];
  logic signed [W-1:0] ring_q [NUM_CH][FRAME_SIZE];

  // write stage (lands one cycle after accept)
  logic                wr_valid_q;
  logic                trig_q;
  logic [CH_W-1:0]     wr_ch_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic signed [W-1:0] wr_data_q;

  // frame emission
  state_t              state_q;
  logic                ready_q;
  logic                out_valid_q;
  logic [IDX_W-1:0]    out_idx_q;
  logic signed [W-1:0] out_sample_q;
  logic                out_last_q;
  logic [CH_W-1:0]     out_ch_q;
  logic                frame_done_q;
  logic [PTR_W-1:0]    start_q;

  logic                accept;
  logic                ch_ok;
  logic                take;
  logic [CH_W-1:0]     in_ch;
  logic signed [W-1:0] x_prev;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] diff;
  logic signed [W-1:0] y;
  logic [CNT_W-1:0]    fill_cur;
  logic [CNT_W-1:0]    new_cur;
  logic [CNT_W-1:0]    fill_nxt;
  logic [CNT_W-1:0]    new_nxt;
  logic [PTR_W-1:0]    wp_cur;
  logic [PTR_W-1:0]    wp_nxt;
  logic                trig;

  logic [IDX_W-1:0]    nxt_idx;
  logic                nxt_last;
  logic [SUM_W-1:0]    rd_raw;
  logic [SUM_W-1:0]    rd_sum;
  logic [PTR_W-1:0]    rd_ptr;
  logic signed [W-1:0] rd_data;

  assign in_ch  = bus.pcm_ch_i;
  assign accept = bus.pcm_valid_i & ready_q;
  assign ch_ok  = ({1'b0, in_ch} < NUM_CH_C);
  assign take   = accept & ch_ok;
  assign x_prev = prev_q[in_ch];

  always_comb begin
    prod  = $signed({{17{x_prev[W-1]}}, x_prev}) * $signed({{(W+1){1'b0}}, ALPHA});
    x_ext = {{17{bus.pcm_i[W-1]}}, bus.pcm_i};
    diff  = x_ext - (prod >>> 15);
    if (diff > SAT_MAX) begin
      y = SAT_MAX[W-1:0];
    end else if (diff < SAT_MIN) begin
      y = SAT_MIN[W-1:0];
    end else begin
      y = diff[W-1:0];
    end
    if (!emph_en_i) begin
      y = bus.pcm_i;
    end
  end

  // Counts are advanced at accept so the trigger is known in time to drop ready.
  always_comb begin
    fill_cur = fill_q[in_ch];
    new_cur  = new_q[in_ch];
    wp_cur   = wp_q[in_ch];
    fill_nxt = (fill_cur == FS_C) ? fill_cur : fill_cur + 1'b1;
    new_nxt  = new_cur + 1'b1;
    wp_nxt   = (wp_cur == LAST_PTR) ? '0 : wp_cur + 1'b1;
    trig     = ((fill_cur != FS_C) && (fill_nxt == FS_C)) ||
               ((fill_cur == FS_C) && (new_nxt == MOVE_C));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        prev_q[i] <= '0;
        fill_q[i] <= '0;
        new_q[i]  <= '0;
        wp_q[i]   <= '0;
      end
      wr_valid_q <= 1'b0;
      trig_q     <= 1'b0;
      wr_ch_q    <= '0;
      wr_ptr_q   <= '0;
      wr_data_q  <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        prev_q[i] <= '0;
        fill_q[i] <= '0;
        new_q[i]  <= '0;
        wp_q[i]   <= '0;
      end
      wr_valid_q <= 1'b0;
      trig_q     <= 1'b0;
      wr_ch_q    <= '0;
      wr_ptr_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_valid_q <= take;
      trig_q     <= take & trig;
      if (take) begin
        prev_q[in_ch] <= bus.pcm_i;
        fill_q[in_ch] <= fill_nxt;
        new_q[in_ch]  <= trig ? '0 : new_nxt;
        wp_q[in_ch]   <= wp_nxt;
        wr_ch_q       <= in_ch;
        wr_ptr_q      <= wp_cur;
        wr_data_q     <= y;
      end
    end
  end

  // Ring contents need no reset: fill count gates every use.
  always_ff @(posedge clk) begin
    if (wr_valid_q) begin
      ring_q[wr_ch_q][wr_ptr_q] <= wr_data_q;
    end
  end

  always_comb begin
    nxt_idx  = out_valid_q ? out_idx_q + 1'b1 : '0;
    nxt_last = (nxt_idx == LAST_IDX);
    rd_raw   = SUM_W'(start_q) + SUM_W'(nxt_idx);
    rd_sum   = (rd_raw >= FS_SUM) ? rd_raw - FS_SUM : rd_raw;
    rd_ptr   = rd_sum[PTR_W-1:0];
    rd_data  = (SUM_W'(nxt_idx) < FS_SUM) ? ring_q[out_ch_q][rd_ptr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_sample_q <= '0;
      out_last_q   <= 1'b0;
      out_ch_q     <= '0;
      frame_done_q <= 1'b0;
      start_q      <= '0;
    end else if (clear_i) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_sample_q <= '0;
      out_last_q   <= 1'b0;
      out_ch_q     <= '0;
      frame_done_q <= 1'b0;
      start_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          frame_done_q <= 1'b0;
          if (take && trig) begin
            ready_q <= 1'b0;
          end
          if (trig_q) begin
            state_q  <= S_EMIT;
            out_ch_q <= wr_ch_q;
            start_q  <= wp_q[wr_ch_q];
          end
        end
        S_EMIT: begin
          if (!out_valid_q || bus.out_ready_i) begin
            if (out_valid_q && out_last_q) begin
              out_valid_q  <= 1'b0;
              out_idx_q    <= '0;
              out_sample_q <= '0;
              out_last_q   <= 1'b0;
              frame_done_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              out_valid_q  <= 1'b1;
              out_idx_q    <= nxt_idx;
              out_sample_q <= rd_data;
              out_last_q   <= nxt_last;
            end
          end
        end
        S_DONE: begin
          frame_done_q <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pcm_ready_o  = ready_q;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_ch_o     = out_ch_q;
  assign bus.out_idx_o    = out_idx_q;
  assign bus.out_sample_o = out_sample_q;
  assign bus.out_last_o   = out_last_q;
  assign bus.frame_done_o = frame_done_q;
endmodule

// File: tb/tb_mfcc_frontend_mc.sv
// Bench for mfcc_frontend_mc: directed and randomized samples against a
// frame-level reference model of pre-emphasis and frame slicing.
module tb_mfcc_frontend_mc;
  localparam int          W     = 16;
  localparam int          NCH   = 2;
  localparam int          FS    = 8;
  localparam int          FM    = 4;
  localparam int          FFT   = 16;
  localparam logic [15:0] ALPHA = 16'd31785;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic emph  = 1'b0;

  always #5 clk = ~clk;

  mfcc_frontend_mc_if #(.SAMPLE_WIDTH(W), .NUM_CH(NCH), .FFT_SIZE(FFT)) bus ();

  mfcc_frontend_mc #(
    .SAMPLE_WIDTH(W), .NUM_CH(NCH), .FRAME_SIZE(FS),
    .FRAME_MOVE(FM), .FFT_SIZE(FFT), .ALPHA(ALPHA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .emph_en_i(emph), .bus(bus)
  );

  int          checks     = 0;
  int          failures   = 0;
  logic [63:0] rx_q[$];
  logic [63:0] exp_q[$];
  int          fd_cnt     = 0;
  int          exp_frames = 0;
  bit          mon_hold   = 1'b1;
  bit          rand_ready = 1'b0;
  int          prev_m[NCH];
  int          cnt_m[NCH];
  int          hist[NCH][$];
  int          got[FFT];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input int ch, input int idx, input int s, input bit last);
    logic [15:0] s16;
    s16 = 16'(s);
    return {23'd0, 8'(ch), 16'(idx), s16, last};
  endfunction

  function automatic logic [63:0] dut_beat();
    return pack(int'(bus.out_ch_o), int'(bus.out_idx_o), int'(bus.out_sample_o), bus.out_last_o);
  endfunction

  // y = x - floor(alpha*prev / 2^15), clipped to the 16-bit range
  function automatic int emph_model(input int x, input int p);
    longint d;
    d = longint'(x) - ((longint'(ALPHA) * longint'(p)) >>> 15);
    if (d > 32767)  d = 32767;
    if (d < -32768) d = -32768;
    return int'(d);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      prev_m[c] = 0;
      cnt_m[c]  = 0;
      hist[c].delete();
    end
    exp_q.delete();
    rx_q.delete();
    fd_cnt     = 0;
    exp_frames = 0;
  endtask

  task automatic chk_idle(input string tag);
    logic [63:0] b;
    b = dut_beat();
    chk(tag, {bus.out_valid_o, bus.frame_done_o, bus.pcm_ready_o, b[60:0]},
             {1'b0, 1'b0, 1'b1, 61'd0});
  endtask

  // out_ready: always 1, or ~50% random
  initial begin
    bus.out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: collects handshaken beats and checks per-cycle protocol rules.
  initial begin
    bit          stall_prev = 1'b0;
    bit          last_prev  = 1'b0;
    logic [63:0] beat_prev  = '0;
    logic [63:0] b;
    bit          hs;
    forever begin
      @(negedge clk);
      b = dut_beat();
      if (mon_hold) begin
        stall_prev = 1'b0;
        last_prev  = 1'b0;
      end else begin
        if (stall_prev)
          chk("stall_hold", {bus.out_valid_o, b[62:0]}, {1'b1, beat_prev[62:0]});
        chk("frame_done_timing", 64'(bus.frame_done_o), 64'(last_prev));
        if (bus.out_valid_o)
          chk("pcm_ready_low_in_emit", 64'(bus.pcm_ready_o), 64'd0);
        hs = bus.out_valid_o & bus.out_ready_i;
        if (hs) rx_q.push_back(b);
        if (bus.frame_done_o) fd_cnt++;
        stall_prev = bus.out_valid_o & ~bus.out_ready_i;
        last_prev  = hs & bus.out_last_o;
        beat_prev  = b;
      end
    end
  end

  task automatic send(input int ch, input int x);
    bit ok;
    bit trig;
    bit seen;
    int y;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus.pcm_valid_i = 1'b1;
    bus.pcm_ch_i    = 1'(ch);
    bus.pcm_i       = 16'(x);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.pcm_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    chk("pcm_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    bus.pcm_valid_i = 1'b0;
    trig = 1'b0;
    if (ch < NCH) begin
      y = emph ? emph_model(x, prev_m[ch]) : x;
      prev_m[ch] = x;
      hist[ch].push_back(y);
      cnt_m[ch]++;
      trig = (cnt_m[ch] == FS) || (cnt_m[ch] > FS && ((cnt_m[ch] - FS) % FM) == 0);
    end
    if (trig) begin
      for (int i = 0; i < FFT; i++)
        exp_q.push_back(pack(ch, i, (i < FS) ? hist[ch][hist[ch].size() - FS + i] : 0, i == FFT - 1));
      exp_frames++;
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (bus.out_valid_o) seen = 1'b1;
      end
      chk("first_valid_latency", 64'(seen), 64'd1);
    end
  endtask

  task automatic wait_and_compare(input string tag);
    int          n;
    bit          ok;
    logic [63:0] e;
    logic [63:0] o;
    n  = exp_q.size();
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (rx_q.size() >= n && fd_cnt >= exp_frames) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_wait"}, 64'(ok), 64'd1);
    repeat (4) @(negedge clk);
    chk({tag, "_beat_count"}, 64'(rx_q.size()), 64'(n));
    chk({tag, "_frame_count"}, 64'(fd_cnt), 64'(exp_frames));
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      o = (rx_q.size() > 0) ? rx_q.pop_front() : '1;
      chk({tag, "_beat"}, o, e);
      got[e[20:17]] = int'($signed(o[16:1]));
    end
    rx_q.delete();
    fd_cnt     = 0;
    exp_frames = 0;
  endtask

  task automatic do_clear();
    @(posedge clk);
    #1;
    mon_hold = 1'b1;
    clear    = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
    chk_idle("clear_outputs");
    mon_hold = 1'b0;
  endtask

  task automatic wait_mid_emit(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rx_q.size() >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_mid_emit"}, 64'({ok, bus.out_valid_o}), 64'd3);
  endtask

  initial begin
    int x;
    bus.pcm_valid_i = 1'b0;
    bus.pcm_ch_i    = '0;
    bus.pcm_i       = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("reset_outputs");
    mon_hold = 1'b0;

    // T1: bypass, one zero-padded frame
    emph = 1'b0;
    for (int n = 1; n <= 8; n++) send(0, n);
    wait_and_compare("t1");
    chk("t1_idx0", 64'(got[0]), 64'd1);
    chk("t1_idx7", 64'(got[7]), 64'd8);
    chk("t1_idx8_pad", 64'(got[8]), 64'd0);
    chk("t1_idx15_pad", 64'(got[15]), 64'd0);

    // T2: pre-emphasis values and saturation
    do_clear();
    emph = 1'b1;
    send(0, 1000);
    send(0, 1000);
    send(0, -32768);
    send(0, 32767);
    for (int n = 0; n < 4; n++) send(0, int'($urandom_range(0, 65535)) - 32768);
    wait_and_compare("t2");
    chk("t2_first", 64'(got[0]), 64'd1000);
    chk("t2_emph_30", 64'(got[1]), 64'd30);
    chk("t2_sat_neg", 64'(got[2]), 64'(-32768));
    chk("t2_sat_pos", 64'(got[3]), 64'd32767);

    // T3: overlapping frames
    do_clear();
    emph = 1'b0;
    for (int n = 1; n <= 12; n++) send(0, n);
    wait_and_compare("t3");
    chk("t3_f2_idx0", 64'(got[0]), 64'd5);
    chk("t3_f2_idx7", 64'(got[7]), 64'd12);

    // T4: interleaved channels
    do_clear();
    for (int n = 1; n <= 8; n++) begin
      send(0, n);
      send(1, 100 + n);
    end
    wait_and_compare("t4");
    chk("t4_ch1_idx0", 64'(got[0]), 64'd101);
    chk("t4_ch1_idx7", 64'(got[7]), 64'd108);

    // T5: random backpressure, then random channel/emphasis/sample soak
    do_clear();
    rand_ready = 1'b1;
    for (int n = 1; n <= 12; n++) send(0, n);
    wait_and_compare("t5");
    for (int n = 0; n < 48; n++) begin
      emph = 1'($urandom_range(0, 1));
      x    = int'($urandom_range(0, 65535)) - 32768;
      send(int'($urandom_range(0, NCH - 1)), x);
    end
    wait_and_compare("t5_rand");
    rand_ready = 1'b0;
    emph       = 1'b0;

    // T6a: clear during emission
    do_clear();
    for (int n = 1; n <= 8; n++) send(0, n);
    wait_mid_emit("t6_clear");
    do_clear();
    for (int n = 1; n <= 7; n++) send(0, 20 + n);
    repeat (30) @(negedge clk);
    chk("t6_clear_no_frame", 64'(rx_q.size() + fd_cnt), 64'd0);
    send(0, 28);
    wait_and_compare("t6_clear");
    chk("t6_clear_idx0", 64'(got[0]), 64'd21);

    // T6b: async reset during emission
    do_clear();
    for (int n = 1; n <= 8; n++) send(0, n);
    wait_mid_emit("t6_rst");
    @(posedge clk);
    #1;
    mon_hold = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("t6_rst_async_valid", 64'({bus.out_valid_o, bus.frame_done_o, bus.out_last_o}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    #1;
    chk_idle("t6_rst_outputs");
    mon_hold = 1'b0;
    for (int n = 1; n <= 7; n++) send(0, 40 + n);
    repeat (30) @(negedge clk);
    chk("t6_rst_no_frame", 64'(rx_q.size() + fd_cnt), 64'd0);
    send(0, 48);
    wait_and_compare("t6_rst");
    chk("t6_rst_idx7", 64'(got[7]), 64'd48);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mfcc_frontend_mc.md
Name: mfcc_frontend_mc

Overview:
Multi-channel successor to the MFCC input stage. Takes time-multiplexed PCM samples tagged with a channel id and applies per-channel pre-emphasis with runtime bypass. Keeps a per-channel ring of the latest FRAME_SIZE samples and emits zero-padded overlapping frames of FFT_SIZE samples, with a valid/ready handshake, to the windowing/FFT stage.

Parameters:
SAMPLE_WIDTH, 16, signed PCM sample width (two's complement)
NUM_CH, 2, number of audio channels (1..8)
FRAME_SIZE, 400, samples per analysis frame
FRAME_MOVE, 160, new samples per channel between frames (1..FRAME_SIZE)
FFT_SIZE, 512, output samples per frame (>= FRAME_SIZE; tail zero-padded)
ALPHA, 16'd31785, pre-emphasis coefficient, Q1.15 unsigned

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear of all channel state
emph_en_i  in  1  1 = pre-emphasis on, 0 = bypass (y = x)
pcm_valid_i  in  1  input sample valid
pcm_ready_o  out  1  input accepted when valid & ready
pcm_ch_i  in  $clog2(NUM_CH) (min 1)  channel of input sample
pcm_i  in  SAMPLE_WIDTH  input sample, signed
out_valid_o  out  1  output sample valid
out_ready_i  in  1  downstream accepts when valid & ready
out_ch_o  out  $clog2(NUM_CH) (min 1)  channel of frame being emitted
out_idx_o  out  $clog2(FFT_SIZE)  sample index within frame, 0..FFT_SIZE-1
out_sample_o  out  SAMPLE_WIDTH  frame sample, signed
out_last_o  out  1  high with idx FFT_SIZE-1
frame_done_o  out  1  one-cycle pulse after last sample handshake

Behaviour:
- Reset (async) and clear_i (sync, priority over all else): all outputs 0, except pcm_ready_o = 1 after release. Per-channel state is cleared: prev sample = 0, fill count = 0, new count = 0, write pointer = 0. FSM goes to IDLE.
- Pre-emphasis on accept: y = x - ((ALPHA * x_prev) >>> 15).
  - Compute at SAMPLE_WIDTH+17 bits, arithmetic shift, truncate toward -inf.
  - Saturate to [-2^(W-1), 2^(W-1)-1].
  - x_prev[ch] <= x on every accept, including when bypassed.
- Write: y goes into ring[ch][wp[ch]]; wp wraps at FRAME_SIZE. fill[ch] saturates at FRAME_SIZE; new[ch] increments. Write lands 1 cycle after accept.
- Frame trigger on the cycle the write lands, if either condition holds:
  - first frame: fill reaches FRAME_SIZE;
  - later frames: fill == FRAME_SIZE and new == FRAME_MOVE.
  - On trigger: new[ch] <= 0, latch ch, start pointer = wp[ch] (oldest sample).
- FSM:
  - IDLE -> EMIT on trigger.
  - EMIT: idx 0..FRAME_SIZE-1 read ring[(start+idx) mod FRAME_SIZE]; idx FRAME_SIZE..FFT_SIZE-1 output 0.
  - EMIT -> DONE on last handshake; DONE pulses frame_done_o for 1 cycle -> IDLE.
- pcm_ready_o = 0 from the accept cycle that causes a trigger through DONE. Only one frame is ever in flight; no input is lost, since the source must hold valid.
- Output handshake:
  - out_valid_o stays high with stable data/idx/ch until accepted.
  - Advance at most 1 sample/cycle; full throughput when out_ready_i is held high.
  - First out_valid_o is <= 3 cycles after the triggering accept.
- Channels are independent; samples for other channels never disturb a channel's counts or prev value.
- pcm_ch_i >= NUM_CH: the sample is accepted and dropped, with no state change.
- emph_en_i is sampled per accept; a change mid-stream affects only subsequent samples.
- FRAME_MOVE == FRAME_SIZE gives non-overlapping frames; FFT_SIZE == FRAME_SIZE gives no padding.

Test Plan:
Params for T1–T4: W=16, NUM_CH=2, FRAME_SIZE=8, FRAME_MOVE=4, FFT_SIZE=16, ALPHA=31785.
- T1 bypass, ch0 samples 1..8, out_ready=1 -> one frame ch0: idx0-7 = 1..8, idx8-15 = 0; out_last at idx15; frame_done 1 cycle later.
- T2 emph on, ch0 samples 1000,1000 -> stored 1000 and 30; 32767 after -32768 -> saturates to 32767.
- T3 bypass, ch0 samples 1..12 -> frames [1..8] then [5..12]; pcm_ready low during each emit; no sample lost.
- T4 interleave ch0/ch1 (ch1 = 100+n), 8 each -> ch0 frame, then ch1 frame [101..108]; ch0 data unaffected.
- T5 random out_ready backpressure (~50%) -> output data/idx held stable while stalled; sample sequence identical to T3.
- T6 assert rst_n low mid-EMIT, and separately clear_i mid-EMIT -> all outputs 0 next cycle; 7 new samples produce no frame, 8th does.
